uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Second-generation UART receiver. Frame format is set at runtime: 5..MAX_WIDTH data bits, none/odd/even parity, and 1 or 2 stop bits.
- Each bit is decided by a 3-sample majority vote around mid-bit.
- Parity errors, framing errors and break conditions are detected.
- Received characters, each with its error flags, are stored in an internal FIFO and read through a valid/ready handshake. Overrun is reported.
- Sits between the pad synchroniser domain and the register/bus interface of the UART peripheral.

Parameters:
- MAX_WIDTH, 8: maximum data bits per frame; rx_dout width.
- SAMPLE_RATE, 16: oversample ticks per bit; must be even and >= 8.
- FIFO_DEPTH, 8: receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cfg_en  in  1  receiver enable
- cfg_data_bits  in  4  data bits per frame, 5..MAX_WIDTH
- cfg_parity  in  2  0 none, 1 odd, 2 even (3 treated as none)
- cfg_stop_bits  in  1  0: one stop bit, 1: two stop bits
- cfg_clk_div  in  16  tick period minus 1, in clk cycles
- uart_rx  in  1  serial input (asynchronous)
- rx_dout  out  MAX_WIDTH  FIFO head data, right-justified, unused upper bits 0
- rx_perr  out  1  FIFO head parity-error flag
- rx_ferr  out  1  FIFO head framing-error flag
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun
- break_det  out  1  one-cycle pulse per break
- busy  out  1  receive state machine not in IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0, FIFO empty, state IDLE, tick counter 0.
  - Reset mid-frame aborts the frame with no push.
- Input conditioning: uart_rx passes through a 2-flop synchroniser.
- Tick generation:
  - Counter runs 0..cfg_clk_div; a tick fires when it equals cfg_clk_div, giving a period of cfg_clk_div+1 clocks.
  - The counter and the per-bit tick count reload to 0 on start-edge detection.
- Bit sampling:
  - Bit value = majority of the synchronised line sampled at ticks SAMPLE_RATE/2-1, SAMPLE_RATE/2 and SAMPLE_RATE/2+1 within the bit.
  - The bit ends at tick SAMPLE_RATE.
- Frame configuration: cfg_data_bits, cfg_parity and cfg_stop_bits are latched at start-edge detection. Changes mid-frame have no effect on the current frame.
- States:
  - IDLE: on a high-to-low transition of the synchronised line with cfg_en=1 -> START.
  - START: mid-bit vote 1 -> IDLE (false start, nothing pushed). At end of bit -> DATA.
  - DATA: LSB first. After the latched number of bits -> PARITY if parity is enabled, else STOP.
  - PARITY:
    - Odd: perr = (XOR of data ^ parity bit) == 0.
    - Even: perr = (XOR of data ^ parity bit) == 1.
    - At end of bit -> STOP.
  - STOP:
    - ferr is set if any stop-bit vote is 0.
    - The frame completes at the mid-bit vote of the last stop bit. This is the push point.
    - Then -> IDLE, or -> BREAK as defined below.
  - BREAK: wait until the synchronised line is 1 for 3 consecutive ticks -> IDLE.
- Break handling:
  - Condition: all data bits 0, parity bit 0 (if present) and first stop vote 0.
  - Response: break_det pulses one cycle at the push point, nothing is pushed, and the state goes to BREAK.
- Non-break framing error: the frame is pushed with ferr=1 and the state returns to IDLE. A new start requires a fresh high-to-low edge.
- cfg_en=0: state forced to IDLE in the next cycle and any in-progress frame is dropped. FIFO contents and overrun are kept.
- FIFO:
  - Entry is {perr, ferr, data}. Outputs are registered.
  - Push becomes visible on rx_valid/rx_dout the cycle after the push point.
  - Pop occurs when rx_valid & rx_ready. The next entry appears the following cycle.
  - Push when full with no simultaneous pop: frame dropped and overrun set.
  - Push when full with a simultaneous pop: both happen and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun: overrun_clr=1 clears it. If set and clear occur in the same cycle, set wins.

Test Plan:
- Setup: cfg_clk_div=3, SAMPLE_RATE=16, so 64 clk per bit.
- 8N1 frame 0xA5, rx_ready=1 -> one rx_valid with rx_dout=0xA5, rx_perr=0, rx_ferr=0; busy low after the stop bit.
- 7E1 frame 0x35 with parity bit driven 1 (wrong) -> rx_dout=0x35, rx_perr=1, rx_ferr=0. Repeat with parity 0 -> rx_perr=0.
- 8N2 frame 0x3C with second stop bit low -> rx_dout=0x3C, rx_ferr=1. Then line held low for 20 bit times -> exactly one break_det pulse, fifo_count unchanged. Line released, then 0x55 sent -> received correctly.
- rx_ready=0, 9 back-to-back 8N1 frames 0x01..0x09 -> fifo_count=8, overrun=1. Draining yields 0x01..0x08 in order. overrun_clr pulse -> overrun=0.
- Line low for 16 clocks (4 ticks) from idle -> false start, no push, busy returns to 0.
- rst=0 for one cycle during the data bits of a frame -> all outputs 0, FIFO empty. Next frame 0xC3 -> received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame format, 3-sample majority voting,
// parity/framing/break detection and a receive FIFO read by valid/ready.
module uart_rx_fifo #(
   parameter int MAX_WIDTH   = 8,
   parameter int SAMPLE_RATE = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_en,
   input  logic [3:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop_bits,
   input  logic [15:0]                   cfg_clk_div,
   input  logic                          uart_rx,
   output logic [MAX_WIDTH-1:0]          rx_dout,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          break_det,
   output logic                          busy
);

   localparam int SW = $clog2(SAMPLE_RATE + 1);
   localparam logic [SW-1:0] S_LO  = SW'(SAMPLE_RATE / 2 - 1);
   localparam logic [SW-1:0] S_MID = SW'(SAMPLE_RATE / 2);
   localparam logic [SW-1:0] S_HI  = SW'(SAMPLE_RATE / 2 + 1);
   localparam logic [SW-1:0] S_END = SW'(SAMPLE_RATE);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = MAX_WIDTH + 2;
   localparam logic [3:0] MAXW = 4'(MAX_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t                 state;
   logic                   sync1, rx_s, rx_prev;
   logic [15:0]            tick_cnt;
   logic                   tick, active;
   logic [SW-1:0]          samp_cnt, samp_next;
   logic                   at_lo, at_mid, at_hi, at_end;
   logic                   s0, s1, vote;
   logic [3:0]             nbits, bit_idx;
   logic [1:0]             par_mode;
   logic                   two_stop, stop_idx;
   logic [MAX_WIDTH-1:0]   data_sr, data_out;
   logic                   par_acc, perr_reg, ferr_reg, all_zero, first_zero;
   logic [1:0]             ones_cnt;
   logic                   start_edge, last_stop, brk_cond, push;
   logic [EW-1:0]          push_word;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [PW-1:0]          rd_ptr, wr_ptr, rd_n, wr_n;
   logic [CW-1:0]          count_n;
   logic                   pop, full, do_push, drop, bypass, valid_n;
   logic [EW-1:0]          head_n;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= uart_rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // Oversample tick divider, realigned to the start edge so sampling is centred on the bits
   always_ff @(posedge clk) begin
      if (!rst) tick_cnt <= '0;
      else if (start_edge || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + 16'd1;
   end

   // Sample-point decode, majority vote and push/break qualification
   always_comb begin
      tick       = (tick_cnt >= cfg_clk_div);
      samp_next  = samp_cnt + SW'(1);
      active     = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
      at_lo      = active && tick && (samp_next == S_LO);
      at_mid     = active && tick && (samp_next == S_MID);
      at_hi      = active && tick && (samp_next == S_HI);
      at_end     = active && tick && (samp_next == S_END);
      vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
      start_edge = (state == IDLE) && cfg_en && rx_prev && !rx_s;
      last_stop  = (state == STOP) && (stop_idx == two_stop);
      brk_cond   = all_zero && ((stop_idx == 1'b0) ? !vote : first_zero);
      push       = cfg_en && last_stop && at_hi && !brk_cond;
      data_out   = data_sr >> (MAXW - nbits);
      push_word  = {perr_reg, ferr_reg | !vote, data_out};
   end

   // Receive state machine: frame assembly, error flags, break handling and busy/break_det outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         break_det  <= 1'b0;
         samp_cnt   <= '0;
         s0         <= 1'b0;
         s1         <= 1'b0;
         nbits      <= 4'd0;
         bit_idx    <= 4'd0;
         par_mode   <= 2'd0;
         two_stop   <= 1'b0;
         stop_idx   <= 1'b0;
         data_sr    <= '0;
         par_acc    <= 1'b0;
         perr_reg   <= 1'b0;
         ferr_reg   <= 1'b0;
         all_zero   <= 1'b0;
         first_zero <= 1'b0;
         ones_cnt   <= 2'd0;
      end else if (!cfg_en) begin
         state     <= IDLE;
         busy      <= 1'b0;
         break_det <= 1'b0;
         samp_cnt  <= '0;
         ones_cnt  <= 2'd0;
      end else begin
         break_det <= 1'b0;
         if (at_lo) s0 <= rx_s;
         if (at_mid) s1 <= rx_s;
         if (active && tick) samp_cnt <= at_end ? '0 : samp_next;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state      <= START;
                  busy       <= 1'b1;
                  samp_cnt   <= '0;
                  if (cfg_data_bits < 4'd5) nbits <= 4'd5;
                  else if (cfg_data_bits > MAXW) nbits <= MAXW;
                  else nbits <= cfg_data_bits;
                  par_mode   <= cfg_parity;
                  two_stop   <= cfg_stop_bits;
                  bit_idx    <= 4'd0;
                  stop_idx   <= 1'b0;
                  data_sr    <= '0;
                  par_acc    <= 1'b0;
                  perr_reg   <= 1'b0;
                  ferr_reg   <= 1'b0;
                  all_zero   <= 1'b1;
                  first_zero <= 1'b0;
               end
            end
            START: begin
               if (at_hi && vote) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (at_end) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (at_hi) begin
                  data_sr <= {vote, data_sr[MAX_WIDTH-1:1]};
                  par_acc <= par_acc ^ vote;
                  if (vote) all_zero <= 1'b0;
               end
               if (at_end) begin
                  if (bit_idx == nbits - 4'd1) begin
                     bit_idx <= 4'd0;
                     state   <= (par_mode == 2'd1 || par_mode == 2'd2) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (at_hi) begin
                  perr_reg <= (par_mode == 2'd1) ? !(par_acc ^ vote) : (par_acc ^ vote);
                  if (vote) all_zero <= 1'b0;
               end
               if (at_end) state <= STOP;
            end
            STOP: begin
               if (at_hi) begin
                  if (!vote) ferr_reg <= 1'b1;
                  if (stop_idx == 1'b0) first_zero <= !vote;
                  if (last_stop) begin
                     samp_cnt <= '0;
                     if (brk_cond) begin
                        break_det <= 1'b1;
                        state     <= BREAK;
                        ones_cnt  <= 2'd0;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end else if (at_end) begin
                  stop_idx <= 1'b1;
               end
            end
            BREAK: begin
               if (tick) begin
                  if (rx_s) begin
                     if (ones_cnt == 2'd2) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ones_cnt <= 2'd0;
                     end else begin
                        ones_cnt <= ones_cnt + 2'd1;
                     end
                  end else begin
                     ones_cnt <= 2'd0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO next-state: pop/push arbitration, drop on full, and head lookahead with write bypass
   always_comb begin
      pop     = rx_valid && rx_ready;
      full    = (fifo_count == CW'(FIFO_DEPTH));
      do_push = push && (!full || pop);
      drop    = push && full && !pop;
      count_n = fifo_count + CW'(do_push) - CW'(pop);
      rd_n    = rd_ptr + PW'(pop);
      wr_n    = wr_ptr + PW'(do_push);
      bypass  = do_push && ((fifo_count - CW'(pop)) == '0);
      head_n  = bypass ? push_word : mem[rd_n];
      valid_n = (count_n != '0);
   end

   // FIFO storage array, written only when a push is accepted
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   // FIFO pointers, occupancy, registered head outputs and sticky overrun (set beats clear)
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         rx_valid   <= 1'b0;
         rx_dout    <= '0;
         rx_perr    <= 1'b0;
         rx_ferr    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rd_ptr     <= rd_n;
         wr_ptr     <= wr_n;
         fifo_count <= count_n;
         rx_valid   <= valid_n;
         if (valid_n) {rx_perr, rx_ferr, rx_dout} <= head_n;
         else {rx_perr, rx_ferr, rx_dout} <= '0;
         if (drop) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at 64 clocks per bit.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_en;
   logic [3:0]  cfg_data_bits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop_bits;
   logic [15:0] cfg_clk_div;
   logic        uart_rx;
   logic [7:0]  rx_dout;
   logic        rx_perr, rx_ferr, rx_valid, rx_ready;
   logic [3:0]  fifo_count;
   logic        overrun, overrun_clr, break_det, busy;

   int          errors = 0;
   int          checks = 0;
   logic [9:0]  got_q[$];
   int          break_cnt = 0;

   uart_rx_fifo #(.MAX_WIDTH(8), .SAMPLE_RATE(16), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits), .cfg_clk_div(cfg_clk_div),
      .uart_rx(uart_rx), .rx_dout(rx_dout), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
      .overrun(overrun), .overrun_clr(overrun_clr), .break_det(break_det), .busy(busy)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Record every accepted FIFO entry {perr, ferr, data} and every break pulse
   always @(negedge clk) begin
      #1;
      if (rx_valid && rx_ready) got_q.push_back({rx_perr, rx_ferr, rx_dout});
      if (break_det) break_cnt++;
   end

   // Watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic send_bit(input logic b);
      uart_rx = b;
      repeat (64) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input logic stop1, input logic two_stop,
                             input logic stop2);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(d[i]);
      if (par_en) send_bit(par_bit);
      send_bit(stop1);
      if (two_stop) send_bit(stop2);
   endtask

   task automatic wait_entries(input int n);
      for (int i = 0; i < 2000 && got_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; cfg_en = 1'b1; cfg_data_bits = 4'd8; cfg_parity = 2'd0;
      cfg_stop_bits = 1'b0; cfg_clk_div = 16'd3; uart_rx = 1'b1;
      rx_ready = 1'b1; overrun_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", rx_valid); end
      checks++; if (rx_dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h want 00", rx_dout); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({break_det, rx_perr, rx_ferr} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {break_det, rx_perr, rx_ferr}); end
      rst = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_8n1();
      logic [9:0] e;
      got_q.delete();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_entries(1);
      repeat (4) @(negedge clk);
      e = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
      checks++; if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL 8n1_count: got %0d entries want 1", got_q.size()); end
      checks++; if (e[7:0] !== 8'hA5) begin errors++; $display("[TB] FAIL 8n1_data: got %h want a5", e[7:0]); end
      checks++; if (e[9:8] !== 2'b00) begin errors++; $display("[TB] FAIL 8n1_flags: got %b want 00", e[9:8]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL 8n1_busy: got %b want 0", busy); end
   endtask

   task automatic test_parity();
      logic [9:0] e;
      cfg_data_bits = 4'd7; cfg_parity = 2'd2;
      got_q.delete();
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_entries(2);
      repeat (4) @(negedge clk);
      checks++; if (got_q.size() !== 2) begin errors++; $display("[TB] FAIL parity_count: got %0d entries want 2", got_q.size()); end
      e = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
      checks++; if (e !== {2'b10, 8'h35}) begin errors++; $display("[TB] FAIL parity_bad: got %h want 235", e); end
      e = (got_q.size() > 1) ? got_q[1] : 10'h3FF;
      checks++; if (e !== {2'b00, 8'h35}) begin errors++; $display("[TB] FAIL parity_good: got %h want 035", e); end
      cfg_data_bits = 4'd8; cfg_parity = 2'd0;
   endtask

   task automatic test_break();
      logic [9:0] e;
      int b0;
      cfg_stop_bits = 1'b1;
      got_q.delete();
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_bit(1'b1);
      e = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
      checks++; if (e !== {2'b01, 8'h3C}) begin errors++; $display("[TB] FAIL stop2_ferr: got %h want 13c", e); end
      got_q.delete();
      b0 = break_cnt;
      for (int i = 0; i < 20; i++) send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      checks++; if (break_cnt - b0 !== 1) begin errors++; $display("[TB] FAIL break_pulses: got %0d want 1", break_cnt - b0); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL break_push: got %0d entries want 0", got_q.size()); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL break_count: got %0d want 0", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy: got %b want 0", busy); end
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_entries(1);
      e = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
      checks++; if (e !== {2'b00, 8'h55}) begin errors++; $display("[TB] FAIL after_break: got %h want 055", e); end
      cfg_stop_bits = 1'b0;
   endtask

   task automatic test_overrun();
      logic [9:0] e;
      rx_ready = 1'b0;
      got_q.delete();
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (fifo_count !== 4'd8) begin errors++; $display("[TB] FAIL ovr_count: got %0d want 8", fifo_count); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b want 1", overrun); end
      checks++; if ({rx_valid, rx_dout} !== {1'b1, 8'h01}) begin errors++; $display("[TB] FAIL ovr_head: got %b/%h want 1/01", rx_valid, rx_dout); end
      rx_ready = 1'b1;
      repeat (20) @(negedge clk);
      rx_ready = 1'b0;
      checks++; if (got_q.size() !== 8) begin errors++; $display("[TB] FAIL drain_count: got %0d entries want 8", got_q.size()); end
      for (int i = 0; i < 8; i++) begin
         e = (got_q.size() > i) ? got_q[i] : 10'h3FF;
         checks++; if (e !== {2'b00, 8'(i + 1)}) begin errors++; $display("[TB] FAIL drain_%0d: got %h want %h", i, e, {2'b00, 8'(i + 1)}); end
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b want 0", overrun); end
      rx_ready = 1'b1;
   endtask

   task automatic test_false_start();
      got_q.delete();
      uart_rx = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fs_busy_high: got %b want 1", busy); end
      repeat (8) @(negedge clk);
      uart_rx = 1'b1;
      repeat (80) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fs_busy_low: got %b want 0", busy); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL fs_push: got %0d entries want 0", got_q.size()); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL fs_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] e;
      rx_ready = 1'b0;
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      checks++; if (fifo_count !== 4'd1) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d want 1", fifo_count); end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      uart_rx = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_busy: got %b want 1", busy); end
      rst = 1'b0;
      uart_rx = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      checks++; if ({rx_valid, rx_perr, rx_ferr, overrun, break_det, busy} !== 6'b0) begin errors++; $display("[TB] FAIL mid_flags: got %b want 000000", {rx_valid, rx_perr, rx_ferr, overrun, break_det, busy}); end
      checks++; if (rx_dout !== 8'h00) begin errors++; $display("[TB] FAIL mid_dout: got %h want 00", rx_dout); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d want 0", fifo_count); end
      rx_ready = 1'b1;
      repeat (128) @(negedge clk);
      got_q.delete();
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_entries(1);
      repeat (4) @(negedge clk);
      e = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
      checks++; if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL mid_next_count: got %0d entries want 1", got_q.size()); end
      checks++; if (e !== {2'b00, 8'hC3}) begin errors++; $display("[TB] FAIL mid_next: got %h want 0c3", e); end
   endtask

   // Run every scenario in order, then print the summary
   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_break();
      test_overrun();
      test_false_start();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
